// File: rtl/gpio_trig_pkg.sv
// Shared types and defaults for the GPIO trigger sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpio_trig_pkg;

  // Default counter widths: phase/config counters and repeat/pulse counters
  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_REP_W = 16;

  // Sequencer phases: waiting for start, initial delay, trigger high, trigger low
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } trig_state_e;

endpackage

// File: rtl/gpio_phase_cnt.sv
// Loadable down-counter timing one sequencer phase; 'last' marks the final cycle.
// Latency: load takes effect on the next edge; 'last' is decoded from the register.
// Backpressure: none; 'dec' only advances while nonzero, so it idles at 0.
module gpio_phase_cnt
  import gpio_trig_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sys_clk_i,
  input  logic             rst_n_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement; decrement saturates at zero
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // A phase loaded with N cycles shows 'last' during its Nth cycle, so the
  // owner can switch phase on the following edge with no dead cycle.
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/gpio_trigger_gen.sv
// Trigger sequencer: after start, waits a delay then emits width/period/repeat pulses.
// Latency: busy rises one edge after an accepted start; trigger rises delay edges after busy.
// Backpressure: none; start outside IDLE is dropped, abort returns to IDLE on the next edge.
module gpio_trigger_gen
  import gpio_trig_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             sys_clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] cfg_delay_i,
  input  logic [CNT_W-1:0] cfg_width_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [REP_W-1:0] cfg_repeat_i,
  output logic             gpio_start_trigger_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [REP_W-1:0] pulse_cnt_o
);

  trig_state_e      state_q;

  // Latched run configuration. The delay is consumed directly by the phase
  // counter at start, so only width, low time and repeat are held.
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] low_q;
  logic [REP_W-1:0] rep_q;

  logic             cfg_bad;
  logic             start_ok;
  logic [REP_W-1:0] pulse_cnt_nxt;
  logic             last_pulse;

  logic             ph_load;
  logic             ph_dec;
  logic [CNT_W-1:0] ph_val;
  logic             ph_last;

  // A zero-width pulse or a period with no low time cannot be generated
  assign cfg_bad       = (cfg_width_i == '0) || (cfg_period_i <= cfg_width_i);
  assign start_ok      = start_i && !cfg_bad;

  // Pulse count after the current high phase ends; repeat of 0 never terminates
  assign pulse_cnt_nxt = pulse_cnt_o + REP_W'(1);
  assign last_pulse    = (rep_q != '0) && (pulse_cnt_nxt == rep_q);

  // One counter times every phase; reload it with the next phase length as each phase ends
  always_comb begin
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = '0;
    if (!abort_i) begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            ph_load = 1'b1;
            ph_val  = (cfg_delay_i != '0) ? cfg_delay_i : cfg_width_i;
          end
        end
        DELAY: begin
          if (ph_last) begin
            ph_load = 1'b1;
            ph_val  = width_q;
          end else begin
            ph_dec  = 1'b1;
          end
        end
        HIGH: begin
          if (ph_last) begin
            ph_load = !last_pulse;
            ph_val  = low_q;
          end else begin
            ph_dec  = 1'b1;
          end
        end
        LOW: begin
          if (ph_last) begin
            ph_load = 1'b1;
            ph_val  = width_q;
          end else begin
            ph_dec  = 1'b1;
          end
        end
        default: begin
          ph_load = 1'b0;
        end
      endcase
    end
  end

  gpio_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .load      (ph_load),
    .load_val  (ph_val),
    .dec       (ph_dec),
    .last      (ph_last)
  );

  // Sequencer FSM with registered trigger, status and pulse count outputs
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      state_q              <= IDLE;
      width_q              <= '0;
      low_q                <= '0;
      rep_q                <= '0;
      gpio_start_trigger_o <= 1'b0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      cfg_err_o            <= 1'b0;
      pulse_cnt_o          <= '0;
    end else begin
      done_o    <= 1'b0;
      cfg_err_o <= 1'b0;
      if (abort_i) begin
        // Abort beats everything, including a start seen in IDLE; count is kept
        state_q              <= IDLE;
        gpio_start_trigger_o <= 1'b0;
        busy_o               <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (cfg_bad) begin
                cfg_err_o <= 1'b1;
              end else begin
                width_q     <= cfg_width_i;
                low_q       <= cfg_period_i - cfg_width_i;
                rep_q       <= cfg_repeat_i;
                pulse_cnt_o <= '0;
                busy_o      <= 1'b1;
                if (cfg_delay_i != '0) begin
                  state_q <= DELAY;
                end else begin
                  state_q              <= HIGH;
                  gpio_start_trigger_o <= 1'b1;
                end
              end
            end
          end
          DELAY: begin
            if (ph_last) begin
              state_q              <= HIGH;
              gpio_start_trigger_o <= 1'b1;
            end
          end
          HIGH: begin
            if (ph_last) begin
              pulse_cnt_o          <= pulse_cnt_nxt;
              gpio_start_trigger_o <= 1'b0;
              if (last_pulse) begin
                // Final pulse has no trailing low phase
                state_q <= IDLE;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end else begin
                state_q <= LOW;
              end
            end
          end
          LOW: begin
            if (ph_last) begin
              state_q              <= HIGH;
              gpio_start_trigger_o <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/gpio_trigger_gen.md
# gpio_trigger_gen

Programmable trigger sequencer that generates `gpio_start_trigger_o`, the level consumed directly by `gpio_wrapper` (which synchronises and fans it out to the 45 GPIO1V8 pins). On a start command it waits a programmed delay and then emits a train of high pulses with programmed width, period and repeat count. Status outputs report progress to the control/register block. An abort input cancels the train.

## Interface
Parameters:
- `CNT_W`, 32: width of the delay, width and period counters and config fields.
- `REP_W`, 16: width of the repeat count and pulse counter.

Ports:
- `sys_clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  start command, single-cycle pulse.
- `abort_i`  in  1  abort command, single-cycle pulse.
- `cfg_delay_i`  in  CNT_W  cycles from accepted start to first rising edge.
- `cfg_width_i`  in  CNT_W  high time per pulse, in cycles.
- `cfg_period_i`  in  CNT_W  rising-edge-to-rising-edge period, in cycles.
- `cfg_repeat_i`  in  REP_W  pulse count; 0 = continuous until abort.
- `gpio_start_trigger_o`  out  1  trigger level to `gpio_wrapper`.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  one-cycle pulse on normal completion.
- `cfg_err_o`  out  1  one-cycle pulse when a start is rejected for invalid config.
- `pulse_cnt_o`  out  REP_W  completed high phases since the last accepted start.

## Operation
- FSM states: IDLE, DELAY, HIGH, LOW.
- IDLE + `start_i`: validate the config.
  - Invalid if width = 0, or period ≤ width: pulse `cfg_err_o` and stay IDLE.
  - Valid: latch all `cfg_*` fields into internal registers and clear `pulse_cnt_o`.
  - Next state: DELAY if delay > 0, else HIGH.
- DELAY: count `delay` cycles, then go to HIGH.
- HIGH: trigger high for `width` cycles. At the end of the phase, increment `pulse_cnt_o`.
  - If this was the last pulse (repeat ≠ 0 and count reaches repeat): go to IDLE and pulse `done_o`.
  - Otherwise go to LOW.
- LOW: trigger low for `period − width` cycles, then go to HIGH.
- The last pulse has no trailing LOW phase.
- `start_i` outside IDLE is ignored. Config input changes during a run have no effect.
- `abort_i` in any non-IDLE state: go to IDLE on the next edge, with trigger low, `busy_o` low and no `done_o`. `pulse_cnt_o` holds its value.
- `abort_i` and `start_i` in the same cycle while in IDLE: abort wins; start is ignored.
- Continuous mode: `pulse_cnt_o` wraps from 2^REP_W−1 to 0. Operation is unaffected.
- `busy_o` = (state ≠ IDLE), registered.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Reset asserted mid-run: next edge returns all outputs to 0 and state to IDLE. No `done_o` or `cfg_err_o`.
- All outputs are registered. Take an accepted start sampled at edge N:
  - `busy_o` rises at edge N+1.
  - `gpio_start_trigger_o` first rises at edge N+1+D.
  - Each high lasts exactly W cycles; rising edges are spaced exactly P cycles apart.
  - After the final pulse k = R, the trigger falls at edge N+1+D+(R−1)·P+W.
  - `done_o` is high for exactly that cycle, `busy_o` falls on the same edge, and `pulse_cnt_o` = R.
- `cfg_err_o` is asserted at edge N+1 for one cycle.
- After completion, a new start is accepted in the first cycle `busy_o` reads 0.
- Counters compare in CNT_W-bit unsigned arithmetic. Low time is `period − width`, computed once at latch time; it cannot underflow because of validation.
- Downstream (`gpio_wrapper`) adds 2 cycles of latency. This block does not compensate for it.

## Structure
- Shared package `gpio_trig_pkg`: FSM state enum (IDLE, DELAY, HIGH, LOW) and default `CNT_W`/`REP_W` constants.
- One sub-module, `gpio_phase_cnt`: a loadable CNT_W down-counter with a terminal-count flag. It is reused for the DELAY, HIGH and LOW phases.
- The FSM, config latch and pulse counter live in the top.

## Test plan
- D=3, W=2, P=5, R=3, start at edge 10:
  - trigger high in cycles 14–15, 19–20 and 24–25;
  - `done_o` at edge 26; `pulse_cnt_o`=3; `busy_o` high over cycles 11–25.
- D=0, W=1, P=2, R=1: trigger high for exactly the one cycle after start; `done_o` next edge; `busy_o` high for 1 cycle.
- Invalid configs:
  - W=4, P=4: `cfg_err_o` 1-cycle pulse; `busy_o` stays 0; trigger stays 0.
  - W=0: same response.
- R=0 (continuous), W=2, P=4:
  - after 6 pulses, `abort_i` during a HIGH phase: trigger and `busy_o` go 0 next edge;
  - no `done_o`; `pulse_cnt_o`=6.
- Mid-run disturbances during HIGH of pulse 2 (R=5):
  - a second `start_i` with new cfg has no effect on timing;
  - `rst_n_i`=0 for 1 cycle: all outputs 0 next edge;
  - a following start behaves as a fresh sequence.
- REP_W=4, continuous mode: `pulse_cnt_o` wraps 15→0 while the trigger period stays exact.
